// File: rtl/dma_2d_engine_if.sv
`default_nettype none
// ============================================================================
// dma_2d_engine_if : HAL read port + GLB write port bundle of the 2-D DMA
// Rev 1.0
// ============================================================================
interface dma_2d_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic                  rd_rsp_valid;
  logic [DATA_WIDTH-1:0] rd_rsp_data;
  logic                  wr_en;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output rd_req_valid, rd_req_addr, wr_en, wr_addr, wr_data,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_ready
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, wr_en, wr_addr, wr_data,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_ready
  );
endinterface
`default_nettype wire

// File: rtl/dma_2d_engine.sv
`default_nettype none
// ============================================================================
// dma_2d_engine : 2-D tile mover DRAM -> GLB with credit-limited read FIFO
// Optional perf counters when DMA_2D_PERF_EN is defined.   Rev 1.0
// ============================================================================
module dma_2d_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  row_len,
  input  logic [LEN_WIDTH-1:0]  row_cnt,
  input  logic [ADDR_WIDTH-1:0] src_stride,
  input  logic [ADDR_WIDTH-1:0] dst_stride,
  output logic                  busy,
  output logic                  done,
`ifdef DMA_2D_PERF_EN
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_stall,
`endif
  dma_2d_engine_if.master       bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE = LEN_WIDTH'(1);
  localparam logic [PTR_W-1:0]      PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]        DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_e;
  state_e state_q, state_d;

  logic [LEN_WIDTH-1:0]  row_len_q, row_len_d, row_cnt_q, row_cnt_d;
  logic [ADDR_WIDTH-1:0] src_stride_q, src_stride_d, dst_stride_q, dst_stride_d;
  logic [ADDR_WIDTH-1:0] src_row_q, src_row_d, rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] dst_row_q, dst_row_d, wr_addr_q, wr_addr_d;
  logic [LEN_WIDTH-1:0]  rd_col_q, rd_col_d, rd_row_q, rd_row_d;
  logic [LEN_WIDTH-1:0]  wr_col_q, wr_col_d, wr_row_q, wr_row_d;
  logic                  reads_done_q, reads_done_d;
  logic [CNT_W-1:0]      outst_q, outst_d, fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic           in_run_w, rd_valid_w, rd_fire_w, push_w, wr_en_w, wr_fire_w, wr_last_w;
  logic [CNT_W:0] credit_used_w;

  assign in_run_w      = (state_q == S_RUN);
  // Credits cover both in-flight reads and buffered data, so the FIFO can never overflow
  assign credit_used_w = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
  assign rd_valid_w    = in_run_w && !reads_done_q && (credit_used_w < DEPTH_C);
  assign rd_fire_w     = rd_valid_w && bus.rd_req_ready;
  assign push_w        = in_run_w && bus.rd_rsp_valid;
  assign wr_en_w       = in_run_w && (fifo_cnt_q != '0);
  assign wr_fire_w     = wr_en_w && bus.wr_ready;
  assign wr_last_w     = (wr_col_q == row_len_q - LEN_ONE) && (wr_row_q == row_cnt_q - LEN_ONE);

  always_comb begin
    state_d      = state_q;
    row_len_d    = row_len_q;
    row_cnt_d    = row_cnt_q;
    src_stride_d = src_stride_q;
    dst_stride_d = dst_stride_q;
    src_row_d    = src_row_q;
    rd_addr_d    = rd_addr_q;
    rd_col_d     = rd_col_q;
    rd_row_d     = rd_row_q;
    reads_done_d = reads_done_q;
    dst_row_d    = dst_row_q;
    wr_addr_d    = wr_addr_q;
    wr_col_d     = wr_col_q;
    wr_row_d     = wr_row_q;
    outst_d      = outst_q;
    fifo_cnt_d   = fifo_cnt_q;
    head_d       = head_q;
    tail_d       = tail_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        row_len_d    = row_len;
        row_cnt_d    = row_cnt;
        src_stride_d = src_stride;
        dst_stride_d = dst_stride;
        src_row_d    = src_addr;
        rd_addr_d    = src_addr;
        dst_row_d    = dst_addr;
        wr_addr_d    = dst_addr;
        rd_col_d     = '0;
        rd_row_d     = '0;
        wr_col_d     = '0;
        wr_row_d     = '0;
        reads_done_d = 1'b0;
        outst_d      = '0;
        fifo_cnt_d   = '0;
        head_d       = '0;
        tail_d       = '0;
        state_d      = (row_len == '0 || row_cnt == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (rd_fire_w) begin
          if (rd_col_q == row_len_q - LEN_ONE) begin
            rd_col_d  = '0;
            src_row_d = src_row_q + src_stride_q;
            rd_addr_d = src_row_q + src_stride_q;
            rd_row_d  = rd_row_q + LEN_ONE;
            if (rd_row_q == row_cnt_q - LEN_ONE) reads_done_d = 1'b1;
          end else begin
            rd_col_d  = rd_col_q + LEN_ONE;
            rd_addr_d = rd_addr_q + STEP;
          end
        end
        if (wr_fire_w) begin
          if (wr_col_q == row_len_q - LEN_ONE) begin
            wr_col_d  = '0;
            dst_row_d = dst_row_q + dst_stride_q;
            wr_addr_d = dst_row_q + dst_stride_q;
            wr_row_d  = wr_row_q + LEN_ONE;
          end else begin
            wr_col_d  = wr_col_q + LEN_ONE;
            wr_addr_d = wr_addr_q + STEP;
          end
          if (wr_last_w) state_d = S_DONE;
        end
        case ({rd_fire_w, push_w})
          2'b10:   outst_d = outst_q + CNT_ONE;
          2'b01:   outst_d = outst_q - CNT_ONE;
          default: outst_d = outst_q;
        endcase
        case ({push_w, wr_fire_w})
          2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
          2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
          default: fifo_cnt_d = fifo_cnt_q;
        endcase
        if (push_w)    tail_d = tail_q + PTR_ONE;
        if (wr_fire_w) head_d = head_q + PTR_ONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      row_len_q    <= '0;
      row_cnt_q    <= '0;
      src_stride_q <= '0;
      dst_stride_q <= '0;
      src_row_q    <= '0;
      rd_addr_q    <= '0;
      rd_col_q     <= '0;
      rd_row_q     <= '0;
      reads_done_q <= 1'b0;
      dst_row_q    <= '0;
      wr_addr_q    <= '0;
      wr_col_q     <= '0;
      wr_row_q     <= '0;
      outst_q      <= '0;
      fifo_cnt_q   <= '0;
      head_q       <= '0;
      tail_q       <= '0;
    end else begin
      state_q      <= state_d;
      row_len_q    <= row_len_d;
      row_cnt_q    <= row_cnt_d;
      src_stride_q <= src_stride_d;
      dst_stride_q <= dst_stride_d;
      src_row_q    <= src_row_d;
      rd_addr_q    <= rd_addr_d;
      rd_col_q     <= rd_col_d;
      rd_row_q     <= rd_row_d;
      reads_done_q <= reads_done_d;
      dst_row_q    <= dst_row_d;
      wr_addr_q    <= wr_addr_d;
      wr_col_q     <= wr_col_d;
      wr_row_q     <= wr_row_d;
      outst_q      <= outst_d;
      fifo_cnt_q   <= fifo_cnt_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_w) mem_q[tail_q] <= bus.rd_rsp_data;
  end

  assign busy             = (state_q == S_LOAD) || in_run_w;
  assign done             = (state_q == S_DONE);
  assign bus.rd_req_valid = rd_valid_w;
  assign bus.rd_req_addr  = rd_addr_q;
  assign bus.wr_en        = wr_en_w;
  assign bus.wr_addr      = wr_addr_q;
  // Data is masked when idle so the port reads zero out of reset
  assign bus.wr_data      = wr_en_w ? mem_q[head_q] : '0;

`ifdef DMA_2D_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (state_q == S_LOAD) begin
      perf_cycles_d = '0;
      perf_stall_d  = '0;
    end else if (in_run_w) begin
      if (perf_cycles_q != '1) perf_cycles_d = perf_cycles_q + 32'd1;
      if ((wr_en_w && !bus.wr_ready) || (rd_valid_w && !bus.rd_req_ready))
        perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif
endmodule
`default_nettype wire

// File: doc/dma_2d_engine.md
Name: dma_2d_engine

Overview:
- Parametrised successor to the controller-side DMA: moves a 2-D tile (row_cnt rows × row_len words, independent byte strides on each side) from DRAM through the host/HAL read port into GLB.
- Read requests and GLB writes are decoupled by an internal response FIFO, so several reads stay outstanding and steady-state throughput is one word per cycle.
- Controller programs descriptor fields, pulses start, waits for done.

Parameters:
ADDR_WIDTH, 32, byte-address width on both sides
DATA_WIDTH, 32, word width; address step per word = DATA_WIDTH/8 (DATA_WIDTH multiple of 8)
LEN_WIDTH, 16, width of row_len and row_cnt
FIFO_DEPTH, 4, response FIFO entries = max outstanding reads (power of 2, >= 2)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  descriptor valid; sampled only in IDLE
src_addr  in  ADDR_WIDTH  DRAM byte address of the tile's first word
dst_addr  in  ADDR_WIDTH  GLB byte address of the tile's first word
row_len  in  LEN_WIDTH  words per row
row_cnt  in  LEN_WIDTH  number of rows
src_stride  in  ADDR_WIDTH  byte offset between row starts, source
dst_stride  in  ADDR_WIDTH  byte offset between row starts, destination
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
rd_req_valid  out  1  read request valid
rd_req_ready  in  1  HAL accepts the request
rd_req_addr  out  ADDR_WIDTH  read byte address
rd_rsp_valid  in  1  read data valid (in-order, any latency >= 1)
rd_rsp_data  in  DATA_WIDTH  read data
wr_en  out  1  GLB write strobe
wr_ready  in  1  GLB accepts the write this cycle
wr_addr  out  ADDR_WIDTH  GLB write byte address
wr_data  out  DATA_WIDTH  GLB write data

Behaviour:
- Reset: FSM to IDLE; all counters, pointers, FIFO and outstanding count cleared. busy, done, rd_req_valid and wr_en are 0; address and data outputs are 0. Reset mid-transfer aborts with no done pulse, and late responses are not consumed.
- FSM: IDLE -> (start) LOAD -> RUN -> DONE -> IDLE.
- LOAD: latch every descriptor field and the pointers. A zero-sized tile (row_len==0 or row_cnt==0) goes LOAD -> DONE with no requests and no writes.
- Read generator:
  - rd_req_valid = RUN && reads remaining && (outstanding + fifo_count) < FIFO_DEPTH.
  - A request is accepted when rd_req_valid && rd_req_ready.
  - rd_req_addr and rd_req_valid hold stable while not ready.
- Read address sequence: on each accepted request, increment the column count and rd_req_addr by DATA_WIDTH/8. At the end of a row, rd_req_addr = previous row start + src_stride and the column count resets.
- Write address sequence: identical walk on the destination side using dst_stride.
- Address arithmetic is modulo 2^ADDR_WIDTH (wraps silently).
- Outstanding count: +1 on an accepted request, -1 on rd_rsp_valid. Both in the same cycle leaves it unchanged.
- FIFO: rd_rsp_valid pushes rd_rsp_data. Push when full cannot occur because of the credit rule; the bench asserts this. Push and pop in the same cycle are both allowed.
- Write port:
  - wr_en = FIFO not empty, in RUN.
  - wr_data = FIFO head; wr_addr = write pointer.
  - The entry pops and the write pointer advances when wr_en && wr_ready.
  - Data and address hold stable while not ready.
- RUN -> DONE on the cycle the final write (row_len*row_cnt-th) is accepted.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- start: ignored while not in IDLE. A new start is accepted the cycle after DONE.
- Latency: first rd_req_valid is 2 cycles after start (IDLE, LOAD). Minimum write latency is 1 cycle after the matching rd_rsp_valid.

Optional Feature:
- Macro: DMA_2D_PERF_EN.
- When defined:
  - Adds output perf_cycles (32 bits), cleared in LOAD and incremented every RUN cycle, saturating at all-ones.
  - Adds output perf_stall (32 bits), counting RUN cycles where wr_en && !wr_ready or rd_req_valid && !rd_req_ready.
  - Both counters hold their value in IDLE until the next LOAD.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- src=0x1000, dst=0x200, row_len=4, row_cnt=1, strides 0, ready always 1, response latency 1 -> reads 0x1000..0x100C, writes 0x200..0x20C with matching data, done pulses once, no extra writes.
- row_len=3, row_cnt=2, src_stride=0x40, dst_stride=0x10 -> read addresses 0x1000,04,08,40,44,48 and write addresses 0x200,04,08,10,14,18.
- Response latency 10, FIFO_DEPTH=4, wr_ready=1 -> outstanding never exceeds 4, rd_req_valid drops while credits are exhausted, all 8 words arrive in order.
- wr_ready held 0 for 20 cycles mid-transfer -> FIFO fills, reads stop at 4 in flight, wr_addr/wr_data stay stable, no data loss after release.
- row_cnt=0 -> done 2 cycles after start, zero requests and writes; start pulsed while busy -> ignored.
- rst_n asserted mid-row, then a fresh 1×2 transfer -> all outputs 0 during reset, no done for the aborted job, new job's addresses restart from the new src/dst.
